sdram_command: RTL

Command sequencer directly downstream of the SDRAM control interface. It consumes the registered decoded command strobes, the registered address and the refresh/initialisation requests. It generates the SDRAM pin commands, the row/bank/column address multiplexing and the write-data output enable. It returns the CM_ACK, REF_ACK and INIT_ACK handshakes to the control interface.

---
 rtl/sdram_command_if.sv | 41 ++++
 rtl/sdram_command.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_command_if.sv
// Bundle between the SDRAM control interface and the command sequencer:
// decoded strobes/address in, handshakes and SDRAM pin drive out.
interface sdram_command_if #(
  parameter int ASIZE    = 23,
  parameter int ROWSIZE  = 12,
  parameter int BANKSIZE = 2
);
  logic                NOP;
  logic                READA;
  logic                WRITEA;
  logic                PRECHARGE;
  logic                IPRECHARGE;
  logic                REFRESH;
  logic                LOAD_MODE;
  logic [ASIZE-1:0]    SADDR;
  logic                REF_REQ;
  logic                INIT_REQ;
  logic                CM_ACK;
  logic                REF_ACK;
  logic                INIT_ACK;
  logic [ROWSIZE-1:0]  SA;
  logic [BANKSIZE-1:0] BA;
  logic                CS_N;
  logic                RAS_N;
  logic                CAS_N;
  logic                WE_N;
  logic                CKE;
  logic                OE;

  modport master (
    output NOP, READA, WRITEA, PRECHARGE, IPRECHARGE, REFRESH, LOAD_MODE,
    output SADDR, REF_REQ, INIT_REQ,
    input  CM_ACK, REF_ACK, INIT_ACK, SA, BA, CS_N, RAS_N, CAS_N, WE_N, CKE, OE
  );

  modport slave (
    input  NOP, READA, WRITEA, PRECHARGE, IPRECHARGE, REFRESH, LOAD_MODE,
    input  SADDR, REF_REQ, INIT_REQ,
    output CM_ACK, REF_ACK, INIT_ACK, SA, BA, CS_N, RAS_N, CAS_N, WE_N, CKE, OE
  );
endinterface

// File: rtl/sdram_command.sv
// SDRAM command sequencer: turns decoded requests into timed pin commands,
// address muxing, write-data enable and the upstream acknowledges.
module sdram_command #(
  parameter int ASIZE    = 23,
  parameter int ROWSIZE  = 12,
  parameter int COLSIZE  = 9,
  parameter int BANKSIZE = 2,
  parameter int T_RCD    = 3,
  parameter int CAS_LAT  = 3,
  parameter int BURST    = 8,
  parameter int T_RP     = 3,
  parameter int T_WR     = 2,
  parameter int T_RC     = 9,
  parameter int T_MRD    = 2
) (
  input logic CLK,
  input logic RESET,
  sdram_command_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACT, RW, RDWAIT, WRWAIT, PRE, REF, LMR} state_t;

  localparam logic [3:0] CMD_DESEL  = 4'b1111;
  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_WRITE  = 4'b0100;
  localparam logic [3:0] CMD_PRE    = 4'b0010;
  localparam logic [3:0] CMD_REF    = 4'b0001;
  localparam logic [3:0] CMD_LMR    = 4'b0000;

  // Counter loads = NOP cycles wanted minus the cycles spent in the transition
  // states (RW, and IDLE before the next command can be registered).
  localparam logic [7:0] LD_ACT = 8'(T_RCD - 1);
  localparam logic [7:0] LD_RD  = 8'(CAS_LAT + BURST + T_RP - 3);
  localparam logic [7:0] LD_WR  = 8'(BURST + T_WR + T_RP - 3);
  localparam logic [7:0] LD_PRE = 8'(T_RP - 2);
  localparam logic [7:0] LD_REF = 8'(T_RC - 2);
  localparam logic [7:0] LD_LMR = 8'(T_MRD - 2);
  localparam logic [7:0] LD_OE  = 8'(BURST - 1);

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [7:0]          oe_cnt_reg, oe_cnt_next;
  logic                write_reg, write_next;
  logic                user_reg, user_next;
  logic [ASIZE-1:0]    addr_reg, addr_next;
  logic [3:0]          cmd_reg, cmd_next;
  logic [ROWSIZE-1:0]  sa_reg, sa_next;
  logic [BANKSIZE-1:0] ba_reg, ba_next;
  logic                cm_ack_reg, cm_ack_next;
  logic                ref_ack_reg, ref_ack_next;
  logic                init_ack_reg, init_ack_next;
  logic                oe_reg, oe_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      oe_cnt_reg   <= '0;
      write_reg    <= 1'b0;
      user_reg     <= 1'b0;
      addr_reg     <= '0;
      cmd_reg      <= CMD_DESEL;
      sa_reg       <= '0;
      ba_reg       <= '0;
      cm_ack_reg   <= 1'b0;
      ref_ack_reg  <= 1'b0;
      init_ack_reg <= 1'b0;
      oe_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      oe_cnt_reg   <= oe_cnt_next;
      write_reg    <= write_next;
      user_reg     <= user_next;
      addr_reg     <= addr_next;
      cmd_reg      <= cmd_next;
      sa_reg       <= sa_next;
      ba_reg       <= ba_next;
      cm_ack_reg   <= cm_ack_next;
      ref_ack_reg  <= ref_ack_next;
      init_ack_reg <= init_ack_next;
      oe_reg       <= oe_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg != 8'd0) ? cnt_reg - 8'd1 : 8'd0;
    write_next = write_reg;
    user_next  = user_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.IPRECHARGE) begin
          state_next = PRE;
          user_next  = 1'b0;
          cnt_next   = LD_PRE;
        end else if (bus.LOAD_MODE) begin
          state_next = LMR;
          addr_next  = bus.SADDR;
          cnt_next   = LD_LMR;
        end else if (bus.REFRESH) begin
          state_next = REF;
          user_next  = 1'b0;
          cnt_next   = LD_REF;
        end else if (!bus.INIT_REQ) begin
          if (bus.REF_REQ) begin
            state_next = REF;
            user_next  = 1'b1;
            cnt_next   = LD_REF;
          end else if (bus.PRECHARGE) begin
            state_next = PRE;
            user_next  = 1'b1;
            cnt_next   = LD_PRE;
          end else if (bus.READA || bus.WRITEA) begin
            state_next = ACT;
            write_next = !bus.READA;
            addr_next  = bus.SADDR;
            cnt_next   = LD_ACT;
          end
        end
      end
      ACT: begin
        if (cnt_reg == 8'd0) state_next = RW;
      end
      RW: begin
        state_next = write_reg ? WRWAIT : RDWAIT;
        cnt_next   = write_reg ? LD_WR : LD_RD;
      end
      default: begin
        if (cnt_reg == 8'd0) state_next = IDLE;
      end
    endcase
  end

  // Commands are registered on entry to their state, so they hit the pins
  // one cycle after the decision.
  always_comb begin
    cmd_next      = CMD_NOP;
    sa_next       = '0;
    ba_next       = '0;
    cm_ack_next   = 1'b0;
    ref_ack_next  = 1'b0;
    init_ack_next = 1'b0;
    oe_next       = (oe_cnt_reg != 8'd0);
    oe_cnt_next   = (oe_cnt_reg != 8'd0) ? oe_cnt_reg - 8'd1 : 8'd0;
    if (state_next != state_reg) begin
      case (state_next)
        ACT: begin
          cmd_next = CMD_ACTIVE;
          ba_next  = addr_next[ASIZE-1 -: BANKSIZE];
          sa_next  = addr_next[COLSIZE +: ROWSIZE];
        end
        RW: begin
          cmd_next                 = write_reg ? CMD_WRITE : CMD_READ;
          ba_next                  = addr_reg[ASIZE-1 -: BANKSIZE];
          sa_next[COLSIZE-1:0]     = addr_reg[COLSIZE-1:0];
          sa_next[10]              = 1'b1;
          cm_ack_next              = 1'b1;
          if (write_reg) begin
            oe_next     = 1'b1;
            oe_cnt_next = LD_OE;
          end
        end
        PRE: begin
          cmd_next    = CMD_PRE;
          sa_next[10] = 1'b1;
          cm_ack_next = user_next;
        end
        REF: begin
          cmd_next     = CMD_REF;
          ref_ack_next = user_next;
        end
        LMR: begin
          cmd_next      = CMD_LMR;
          sa_next       = addr_next[ROWSIZE-1:0];
          init_ack_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.CS_N     = cmd_reg[3];
  assign bus.RAS_N    = cmd_reg[2];
  assign bus.CAS_N    = cmd_reg[1];
  assign bus.WE_N     = cmd_reg[0];
  assign bus.SA       = sa_reg;
  assign bus.BA       = ba_reg;
  assign bus.CM_ACK   = cm_ack_reg;
  assign bus.REF_ACK  = ref_ack_reg;
  assign bus.INIT_ACK = init_ack_reg;
  assign bus.OE       = oe_reg;
  assign bus.CKE      = 1'b1;

endmodule
